// File: rtl/ika2151_timer_unit.sv
// ika2151_timer_unit: Timer A / Timer B counters, sticky status flags,
// IRQ output and the Timer A overflow strobe used by the CSM key-on path.
// Everything advances on phi1 negative clock-enable edges; a tick is an
// enabled edge in cycle 31 of the frame, or every enabled edge in test mode.
module ika2151_timer_unit #(
   parameter int TA_WIDTH    = 10,
   parameter int TB_WIDTH    = 8,
   parameter int TB_PRESCALE = 16
) (
   input  logic                i_EMUCLK,
   input  logic                i_MRST_n,
   input  logic                i_phi1_NCEN_n,
   input  logic                i_CYCLE_31,
   input  logic                i_TEST_FAST,
   input  logic [TA_WIDTH-1:0] i_CLKA,
   input  logic [TB_WIDTH-1:0] i_CLKB,
   input  logic                i_LOAD_A,
   input  logic                i_LOAD_B,
   input  logic                i_IRQEN_A,
   input  logic                i_IRQEN_B,
   input  logic                i_FRST_A,
   input  logic                i_FRST_B,
   output logic                o_TIMERA_FLAG,
   output logic                o_TIMERB_FLAG,
   output logic                o_TIMERA_OVFL,
   output logic                o_IRQ_n,
   output logic [TA_WIDTH-1:0] o_CNTA
);

   // A one-count prescaler still needs a 1-bit register to stay legal.
   localparam int PS_W = (TB_PRESCALE > 1) ? $clog2(TB_PRESCALE) : 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(TB_PRESCALE - 1);

   logic                en;
   logic                tick;
   logic                run_a;
   logic                run_b;
   logic                ovf_a;
   logic                b_cnt;
   logic                ovf_b;

   logic [TA_WIDTH-1:0] cnt_a;
   logic [TB_WIDTH-1:0] cnt_b;
   logic [PS_W-1:0]     presc;
   logic                load_a_q;
   logic                load_b_q;
   logic                flag_a;
   logic                flag_b;
   logic                ovfl_a;

   // Decode enable/tick and the overflow events. A timer only counts once
   // LOAD was already high on the previous enabled edge, so the edge that
   // first sees LOAD high still preloads.
   always_comb begin
      en    = ~i_phi1_NCEN_n;
      tick  = en & (i_CYCLE_31 | i_TEST_FAST);
      run_a = i_LOAD_A & load_a_q;
      run_b = i_LOAD_B & load_b_q;
      ovf_a = tick & run_a & (&cnt_a);
      b_cnt = tick & run_b & (presc == PS_LAST);
      ovf_b = b_cnt & (&cnt_b);
   end

   // Timer A counter, preload tracking and the one-interval overflow strobe.
   always_ff @(posedge i_EMUCLK) begin
      if (!i_MRST_n) begin
         cnt_a    <= '0;
         load_a_q <= 1'b0;
         ovfl_a   <= 1'b0;
      end else if (en) begin
         load_a_q <= i_LOAD_A;
         ovfl_a   <= ovf_a;
         if (!run_a)
            cnt_a <= i_CLKA;
         else if (tick)
            cnt_a <= ovf_a ? i_CLKA : cnt_a + TA_WIDTH'(1);
      end
   end

   // Timer B prescaler and counter; the counter steps once per prescaler wrap.
   always_ff @(posedge i_EMUCLK) begin
      if (!i_MRST_n) begin
         cnt_b    <= '0;
         presc    <= '0;
         load_b_q <= 1'b0;
      end else if (en) begin
         load_b_q <= i_LOAD_B;
         if (!run_b) begin
            presc <= '0;
            cnt_b <= i_CLKB;
         end else if (tick) begin
            presc <= (presc == PS_LAST) ? '0 : presc + PS_W'(1);
            if (b_cnt)
               cnt_b <= ovf_b ? i_CLKB : cnt_b + TB_WIDTH'(1);
         end
      end
   end

   // Sticky flags: an enabled overflow sets, FRST clears, set beats clear.
   always_ff @(posedge i_EMUCLK) begin
      if (!i_MRST_n) begin
         flag_a <= 1'b0;
         flag_b <= 1'b0;
      end else if (en) begin
         flag_a <= (ovf_a & i_IRQEN_A) | (flag_a & ~i_FRST_A);
         flag_b <= (ovf_b & i_IRQEN_B) | (flag_b & ~i_FRST_B);
      end
   end

   assign o_TIMERA_FLAG = flag_a;
   assign o_TIMERB_FLAG = flag_b;
   assign o_TIMERA_OVFL = ovfl_a;
   assign o_IRQ_n       = ~(flag_a | flag_b);
   assign o_CNTA        = cnt_a;

endmodule

// File: tb/tb_ika2151_timer_unit.sv
// Testbench for ika2151_timer_unit: directed scenarios followed by random
// stimulus, all outputs compared every cycle against a behavioural model.
module tb_ika2151_timer_unit;

   localparam int TA_W = 10;
   localparam int TB_W = 8;
   localparam int PRE  = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            mrst_n, ncen_n, cyc31, fast;
   logic            load_a, load_b, irqen_a, irqen_b, frst_a, frst_b;
   logic [TA_W-1:0] clka;
   logic [TB_W-1:0] clkb;
   logic            flag_a, flag_b, ovfl, irq_n;
   logic [TA_W-1:0] cnta;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model state: counts as plain integers that overflow when
   // they reach 2^W, B prescale as ticks since last B-count.
   int ma, mb, mp;
   bit fa, fb, mov, pla, plb;

   ika2151_timer_unit #(.TA_WIDTH(TA_W), .TB_WIDTH(TB_W), .TB_PRESCALE(PRE)) dut (
      .i_EMUCLK      (clk),
      .i_MRST_n      (mrst_n),
      .i_phi1_NCEN_n (ncen_n),
      .i_CYCLE_31    (cyc31),
      .i_TEST_FAST   (fast),
      .i_CLKA        (clka),
      .i_CLKB        (clkb),
      .i_LOAD_A      (load_a),
      .i_LOAD_B      (load_b),
      .i_IRQEN_A     (irqen_a),
      .i_IRQEN_B     (irqen_b),
      .i_FRST_A      (frst_a),
      .i_FRST_B      (frst_b),
      .o_TIMERA_FLAG (flag_a),
      .o_TIMERB_FLAG (flag_b),
      .o_TIMERA_OVFL (ovfl),
      .o_IRQ_n       (irq_n),
      .o_CNTA        (cnta)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step();
      bit tk, oa, ob, run_a, run_b;
      if (!mrst_n) begin
         ma = 0; mb = 0; mp = 0; fa = 0; fb = 0; mov = 0; pla = 0; plb = 0;
         return;
      end
      if (ncen_n) return;
      tk    = cyc31 || fast;
      run_a = load_a && pla;
      run_b = load_b && plb;
      pla   = load_a;
      plb   = load_b;
      oa = 0;
      ob = 0;
      if (!run_a) ma = int'(clka);
      else if (tk) begin
         ma++;
         if (ma == (1 << TA_W)) begin ma = int'(clka); oa = 1; end
      end
      if (!run_b) begin
         mb = int'(clkb);
         mp = 0;
      end else if (tk) begin
         mp++;
         if (mp == PRE) begin
            mp = 0;
            mb++;
            if (mb == (1 << TB_W)) begin mb = int'(clkb); ob = 1; end
         end
      end
      fa  = (oa && irqen_a) || (fa && !frst_a);
      fb  = (ob && irqen_b) || (fb && !frst_b);
      mov = oa;
   endtask

   // One EMUCLK cycle: edge, model update, then compare just after the edge.
   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      chk("cnta",   32'(cnta),   32'(ma));
      chk("flag_a", 32'(flag_a), 32'(fa));
      chk("flag_b", 32'(flag_b), 32'(fb));
      chk("ovfl",   32'(ovfl),   32'(mov));
      chk("irq_n",  32'(irq_n),  32'(!(fa || fb)));
   endtask

   // Frame tick followed by one disabled cycle that must be ignored.
   task automatic tick(input int n);
      repeat (n) begin
         ncen_n = 1'b0; cyc31 = 1'b1; step();
         ncen_n = 1'b1; step();
      end
      cyc31 = 1'b0;
   endtask

   // Enabled edge outside cycle 31.
   task automatic idle_en();
      ncen_n = 1'b0; cyc31 = 1'b0; step();
      ncen_n = 1'b1;
   endtask

   initial begin
      mrst_n = 1'b0; ncen_n = 1'b1; cyc31 = 1'b0; fast = 1'b0;
      load_a = 1'b0; load_b = 1'b0; irqen_a = 1'b0; irqen_b = 1'b0;
      frst_a = 1'b0; frst_b = 1'b0; clka = '0; clkb = '0;

      // Reset with enable high.
      repeat (4) step();
      chk("rst_cnta", 32'(cnta), 32'h0);
      chk("rst_flags", 32'({flag_a, flag_b, ovfl}), 32'h0);
      chk("rst_irq_n", 32'(irq_n), 32'h1);

      // Preload while LOAD_A low.
      mrst_n = 1'b1; clka = 10'h155;
      idle_en();
      chk("preload_a", 32'(cnta), 32'h155);

      // Timer A period of 3 ticks.
      clka = 10'h3FD; irqen_a = 1'b1; load_a = 1'b1;
      idle_en();
      chk("a_load_edge", 32'(cnta), 32'h3FD);
      tick(1); chk("a_t1", 32'(cnta), 32'h3FE);
      tick(1); chk("a_t2", 32'(cnta), 32'h3FF);
      tick(1);
      chk("a_t3_cnt", 32'(cnta), 32'h3FD);
      chk("a_t3_flag", 32'(flag_a), 32'h1);
      chk("a_t3_irq", 32'(irq_n), 32'h0);
      chk("a_t3_ovfl_held", 32'(ovfl), 32'h1);
      idle_en();
      chk("a_ovfl_drop", 32'(ovfl), 32'h0);

      // Flag race: clear on the overflowing edge loses, next edge clears.
      tick(2);
      frst_a = 1'b1;
      tick(1);
      chk("race_set_wins", 32'(flag_a), 32'h1);
      chk("race_ovfl", 32'(ovfl), 32'h1);
      idle_en();
      frst_a = 1'b0;
      chk("race_clear", 32'(flag_a), 32'h0);
      chk("race_irq_n", 32'(irq_n), 32'h1);

      // Timer B: first flag after 32 ticks.
      load_a = 1'b0; clkb = 8'hFE; irqen_b = 1'b1; load_b = 1'b1;
      idle_en();
      tick(31); chk("b_t31", 32'(flag_b), 32'h0);
      tick(1);  chk("b_t32", 32'(flag_b), 32'h1);
      frst_b = 1'b1; idle_en(); frst_b = 1'b0;
      chk("b_clear", 32'(flag_b), 32'h0);
      irqen_b = 1'b0;
      tick(64); chk("b_irqen_off", 32'(flag_b), 32'h0);

      // Mid-run LOAD_B drop and restart.
      irqen_b = 1'b1;
      tick(20);
      load_b = 1'b0; idle_en();
      load_b = 1'b1; idle_en();
      tick(31); chk("b_restart_t31", 32'(flag_b), 32'h0);
      tick(1);  chk("b_restart_t32", 32'(flag_b), 32'h1);

      // Fast mode, CLKA all-ones: overflow on every enabled edge, no flag.
      fast = 1'b1; clka = 10'h3FF; irqen_a = 1'b0; load_a = 1'b1;
      idle_en();
      for (int i = 0; i < 4; i++) begin
         ncen_n = 1'b0; step();
         chk("fast_ovfl", 32'(ovfl), 32'h1);
         chk("fast_flag", 32'(flag_a), 32'h0);
      end
      fast = 1'b0;

      // Reset mid-count, enable high.
      mrst_n = 1'b0; ncen_n = 1'b1; step();
      chk("midrst_cnta", 32'(cnta), 32'h0);
      chk("midrst_flags", 32'({flag_a, flag_b, ovfl}), 32'h0);
      mrst_n = 1'b1;

      // Random stimulus.
      load_a = 1'b1; load_b = 1'b1; irqen_a = 1'b1; irqen_b = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         mrst_n = ($urandom_range(0, 299) != 0);
         ncen_n = 1'($urandom_range(0, 1));
         cyc31  = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 199) == 0) fast = ~fast;
         if ($urandom_range(0, 99) == 0) load_a = ~load_a;
         if ($urandom_range(0, 99) == 0) load_b = ~load_b;
         if ($urandom_range(0, 15) == 0) irqen_a = ~irqen_a;
         if ($urandom_range(0, 15) == 0) irqen_b = ~irqen_b;
         if ($urandom_range(0, 63) == 0)
            clka = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'(10'h3F0 | $urandom_range(0, 15));
         if ($urandom_range(0, 63) == 0)
            clkb = 8'(8'hFC | $urandom_range(0, 3));
         frst_a = ($urandom_range(0, 15) == 0);
         frst_b = ($urandom_range(0, 15) == 0);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ika2151_timer_unit.md
# ika2151_timer_unit

Parametrised timer block for the IKA2151 core. It supplies Timer A/B flags and the Timer A overflow strobe that the register block and the CSM key-on path consume. Counter widths and the Timer B prescale ratio are parameters, so derivative OPx cores reuse the same unit. Both timers advance once per sample frame on the phi1 negative clock-enable. A test-mode fast tick advances them on every enabled cycle.

## Interface
Parameters:
- TA_WIDTH, 10, Timer A counter width
- TB_WIDTH, 8, Timer B counter width
- TB_PRESCALE, 16, frame ticks per Timer B count (≥1)

Ports:
- i_EMUCLK  in  1  emulator master clock; sole clock
- i_MRST_n  in  1  reset; synchronous, active-low
- i_phi1_NCEN_n  in  1  clock enable, active-low; all state changes only when low ("enabled edge")
- i_CYCLE_31  in  1  frame marker; tick = enabled edge with i_CYCLE_31=1
- i_TEST_FAST  in  1  1: tick = every enabled edge
- i_CLKA  in  TA_WIDTH  Timer A reload value
- i_CLKB  in  TB_WIDTH  Timer B reload value
- i_LOAD_A, i_LOAD_B  in  1  run enables (level)
- i_IRQEN_A, i_IRQEN_B  in  1  flag-set enables (level)
- i_FRST_A, i_FRST_B  in  1  flag clear strobes, sampled on enabled edges
- o_TIMERA_FLAG, o_TIMERB_FLAG  out  1  sticky status flags
- o_TIMERA_OVFL  out  1  Timer A overflow strobe (CSM)
- o_IRQ_n  out  1  ~(A flag | B flag)
- o_CNTA  out  TA_WIDTH  Timer A count (debug/readback)

## Operation
- Reset (i_MRST_n=0 at any EMUCLK edge, overrides enable): cnt A=0, cnt B=0, prescaler=0, flags=0, o_TIMERA_OVFL=0, o_IRQ_n=1.
- Timer A, LOAD_A=0: cnt A ← i_CLKA on every enabled edge (hold/preload). No overflow, no flag.
- Timer A, LOAD_A=1, tick:
  - cnt A ≠ all-ones → cnt A+1.
  - cnt A = all-ones → reload i_CLKA and overflow event.
  - Non-tick enabled edges hold.
- Period = 2^TA_WIDTH − CLKA ticks. CLKA all-ones → overflow on every tick.
- Timer B prescaler, LOAD_B=0: cleared to 0 and cnt B ← i_CLKB on each enabled edge.
- Timer B, LOAD_B=1:
  - Each tick increments the prescaler mod TB_PRESCALE.
  - A tick with prescaler = TB_PRESCALE−1 is a B-count.
  - A B-count with cnt B = all-ones reloads i_CLKB and raises an overflow event; otherwise cnt B+1.
  - Period = TB_PRESCALE·(2^TB_WIDTH − CLKB) ticks.
  - TB_PRESCALE=1 → every tick is a B-count.
- Flags:
  - An overflow event sets the flag only if the matching IRQEN is 1 on that edge.
  - FRST clears the flag.
  - Set and clear on the same edge → set wins.
  - Clearing IRQEN does not clear a set flag.
- o_TIMERA_OVFL = 1 after any Timer A overflow event, regardless of IRQEN, else 0. Updated on enabled edges only.
- Mid-run LOAD drop: the next enabled edge preloads; prescaler resets; flags untouched.
- Changing i_CLKA/i_CLKB while running affects only the next reload.

## Timing
- All outputs registered; single-edge latency from the causing enabled edge.
- Flag, IRQ and OVFL are valid in the same EMUCLK cycle as the reloaded count.
- o_TIMERA_OVFL is high for exactly one enable interval (until the next enabled edge).
- o_IRQ_n is derived from the registered flags with no extra cycle.
- Enable high: every register holds; strobes on non-enabled cycles are ignored.
- LOAD 0→1 sampled on edge N: edge N is still a preload edge; counting starts at the first tick after N.

## Test plan
- Reset/idle: assert i_MRST_n=0 with enable high for 4 EMUCLK → all outputs at reset values. Release, LOAD_A=0, CLKA=0x155 → o_CNTA=0x155 after first enabled edge.
- Timer A period: CLKA=0x3FD, IRQEN_A=1, LOAD_A=1 → o_CNTA 0x3FE, 0x3FF, then 0x3FD on tick 3. On tick 3: o_TIMERA_FLAG=1, o_IRQ_n=0, OVFL high one enable interval. Repeats every 3 ticks.
- Timer B period: CLKB=0xFE, TB_PRESCALE=16, IRQEN_B=1 → o_TIMERB_FLAG first sets on tick 32. With IRQEN_B=0 the flag never sets.
- Flag race: FRST_A pulsed on the overflowing edge → flag stays 1. FRST_A on the next enabled edge → flag 0, o_IRQ_n=1 (B clear).
- Fast mode/CSM: i_TEST_FAST=1, CLKA=0x3FF, IRQEN_A=0 → OVFL high on every enabled edge, flag stays 0.
- Mid-run: drop LOAD_B after 20 ticks, re-raise → next flag at 32 ticks after restart. Assert reset mid-count → counters 0, flags 0 on that edge.
